// File: rtl/board_led_pkg.sv
// Shared encodings for the board LED pattern engine: modes, switch/key field
// positions and the decoded switch control word.
package board_led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam int SW_MODE_LSB = 0;
    localparam int SW_DIR      = 2;
    localparam int SW_FAST     = 3;

    localparam int KEY_PAUSE   = 0;
    localparam int KEY_RESTART = 1;

    // Only this many keys/switches carry a function; the rest are ignored.
    localparam int NB_KEY_USED = 2;
    localparam int NB_SW_USED  = 4;

    typedef struct packed {
        logic  fast;
        logic  dir;
        mode_e mode;
    } sw_ctrl_t;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by an independent debounce counter per bit.
// A bit's level only follows the sample after CYCLES consecutive differing samples.
module input_debounce #(
    parameter int               WIDTH     = 1,
    parameter int               CYCLES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int                CNT_W    = $clog2(CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= RESET_VAL[i];
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                lvl <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign dout[i] = lvl;
    end

endmodule

// File: rtl/board_led_ctrl.sv
// LED pattern engine: debounced keys/switches select an animated pattern
// (static, blink, chase, count) stepped by a pausable prescaler.
module board_led_ctrl
    import board_led_pkg::*;
#(
    parameter int NB_LED          = 8,
    parameter int NB_KEY          = 2,
    parameter int NB_SW           = 4,
    parameter int TICK_DIV        = 5000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NB_KEY-1:0] key_n,
    input  logic [NB_SW-1:0]  sw,
    output logic [NB_LED-1:0] led,
    output logic              paused,
    output logic              tick
);

    localparam int               PRE_W     = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] TERM_SLOW = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] TERM_FAST = PRE_W'(TICK_DIV / 2 - 1);

    function automatic logic [NB_LED-1:0] alt_bits();
        logic [NB_LED-1:0] v;
        for (int i = 0; i < NB_LED; i++) v[i] = (i % 2 == 0);
        return v;
    endfunction

    localparam logic [NB_LED-1:0] STATIC_PAT = alt_bits();

    logic [NB_KEY_USED-1:0] key_db, key_prev, key_press;
    logic [NB_SW_USED-1:0]  sw_db;
    sw_ctrl_t               ctrl;
    mode_e                  mode_prev;
    logic                   loaded;
    logic                   reload;
    logic [PRE_W-1:0]       pre_cnt, term;
    logic [NB_LED-1:0]      init_pat, step_pat;

    input_debounce #(
        .WIDTH     (NB_KEY_USED),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL ('1)
    ) u_key_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (key_n[NB_KEY_USED-1:0]),
        .dout  (key_db)
    );

    input_debounce #(
        .WIDTH     (NB_SW_USED),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL ('0)
    ) u_sw_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw[NB_SW_USED-1:0]),
        .dout  (sw_db)
    );

    // loaded is low only on the first edge out of reset, forcing the initial load.
    always_comb begin
        key_press = key_prev & ~key_db;
        ctrl.mode = mode_e'(sw_db[SW_MODE_LSB +: 2]);
        ctrl.dir  = sw_db[SW_DIR];
        ctrl.fast = sw_db[SW_FAST];
        term      = ctrl.fast ? TERM_FAST : TERM_SLOW;
        reload    = !loaded || key_press[KEY_RESTART] || (ctrl.mode != mode_prev);
    end

    always_comb begin
        init_pat = '0;
        step_pat = led;
        case (ctrl.mode)
            MODE_STATIC: init_pat = STATIC_PAT;
            MODE_BLINK: begin
                init_pat = '1;
                step_pat = ~led;
            end
            MODE_CHASE: begin
                init_pat = NB_LED'(1);
                step_pat = ctrl.dir ? {led[0], led[NB_LED-1:1]}
                                    : {led[NB_LED-2:0], led[NB_LED-1]};
            end
            MODE_COUNT: step_pat = led + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led       <= '0;
            paused    <= 1'b0;
            tick      <= 1'b0;
            pre_cnt   <= '0;
            key_prev  <= '1;
            mode_prev <= MODE_STATIC;
            loaded    <= 1'b0;
        end else begin
            key_prev  <= key_db;
            mode_prev <= ctrl.mode;
            loaded    <= 1'b1;
            paused    <= paused ^ key_press[KEY_PAUSE];
            // A reload discards any step due on the same edge.
            if (reload) begin
                led     <= init_pat;
                pre_cnt <= '0;
                tick    <= 1'b0;
            end else if (paused) begin
                tick <= 1'b0;
            end else if (pre_cnt >= term) begin
                led     <= step_pat;
                pre_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
                tick    <= 1'b0;
            end
        end
    end

endmodule
